// File: rtl/ether_rx_frame.sv
// ether_rx_frame: GMII receive framer.
// Strips preamble/SFD, forwards frame bytes through a 5-byte delay line so the
// 4 FCS bytes are never emitted, and flags each frame good/bad at its last byte
// (CRC-32 residue, length window, phy_rx_er during data).
// Optional good/bad frame counters are built only when the macro
// ETHER_RX_FRAME_STATS_EN is defined; otherwise stat_good/stat_bad read 0.
module ether_rx_frame #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        phy_rx_clk,
  input  logic        rst,
  input  logic        phy_rx_dv,
  input  logic        phy_rx_er,
  input  logic [7:0]  phy_rx_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_ok,
  output logic        out_err,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
  localparam logic [10:0] LEN_MIN     = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] LEN_MAX     = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] LEN_SAT     = 11'h7FF;
  localparam logic [10:0] DLY_DEPTH   = 11'd5;

  // Reflected CRC-32 update over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  byte_in);
    logic [31:0] c;
    c = crc_in ^ {24'h00_0000, byte_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [10:0]     len_q, len_d;
  logic [31:0]     crc_q, crc_d;
  logic            rxer_q, rxer_d;
  logic [4:0][7:0] dly_q, dly_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;

  logic frame_bad;
  logic frame_end;
  logic frame_emits;

  // Verdict for the frame ending this cycle; phy_rx_er on the dv-fall cycle
  // itself still counts since the FSM is in DATA then.
  assign frame_bad   = (crc_q != CRC_RESIDUE) | (len_q < LEN_MIN) |
                       (len_q > LEN_MAX) | rxer_q | phy_rx_er;
  assign frame_end   = (state_q == S_DATA) && !phy_rx_dv;
  assign frame_emits = (len_q >= DLY_DEPTH);

  // Next-state, byte accounting and output staging.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    crc_d   = crc_q;
    rxer_d  = rxer_q;
    dly_d   = dly_q;
    valid_d = 1'b0;
    data_d  = 8'h00;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (phy_rx_dv) begin
          state_d = (phy_rx_data == 8'h55) ? S_PREAMBLE : S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!phy_rx_dv) begin
          state_d = S_IDLE;
        end else if (phy_rx_data == 8'hD5) begin
          state_d = S_DATA;
          len_d   = 11'd0;
          crc_d   = CRC_INIT;
          rxer_d  = 1'b0;
        end else if (phy_rx_data != 8'h55) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (phy_rx_dv) begin
          if (len_q != LEN_SAT) begin
            len_d = len_q + 11'd1;
          end
          crc_d  = crc32_byte(crc_q, phy_rx_data);
          rxer_d = rxer_q | phy_rx_er;
          dly_d  = {dly_q[3:0], phy_rx_data};
          // Oldest delay-line entry is 5 bytes behind the one arriving now.
          if (frame_emits) begin
            valid_d = 1'b1;
            data_d  = dly_q[4];
            sof_d   = (len_q == DLY_DEPTH);
          end
        end else begin
          // dv fell: the oldest entry is the last non-FCS byte.
          state_d = S_IDLE;
          if (frame_emits) begin
            valid_d = 1'b1;
            data_d  = dly_q[4];
            sof_d   = (len_q == DLY_DEPTH);
            eof_d   = 1'b1;
            ok_d    = !frame_bad;
            err_d   = frame_bad;
          end
        end
      end
      S_DROP: begin
        if (!phy_rx_dv) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_DROP;
    endcase
  end

  // Framer state and registered outputs; reset parks in DROP so a frame
  // already on the wire is discarded.
  always_ff @(posedge phy_rx_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_DROP;
      len_q   <= 11'd0;
      crc_q   <= CRC_INIT;
      rxer_q  <= 1'b0;
      dly_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      rxer_q  <= rxer_d;
      dly_q   <= dly_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign out_ok    = ok_q;
  assign out_err   = err_q;

`ifdef ETHER_RX_FRAME_STATS_EN
  logic        done_q, done_d;
  logic        good_q, good_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

  // Counters bump one cycle after the frame ends; frames too short to emit
  // anything are always bad.
  always_comb begin
    done_d     = frame_end;
    good_d     = frame_end && frame_emits && !frame_bad;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (done_q) begin
      if (good_q) begin
        if (good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
      end else begin
        if (bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge phy_rx_clk or negedge rst) begin
    if (!rst) begin
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      good_cnt_q <= 16'h0000;
      bad_cnt_q  <= 16'h0000;
    end else begin
      done_q     <= done_d;
      good_q     <= good_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign stat_good = good_cnt_q;
  assign stat_bad  = bad_cnt_q;
`else
  assign stat_good = 16'h0000;
  assign stat_bad  = 16'h0000;
`endif

endmodule

// File: tb/tb_ether_rx_frame.sv
// Directed bench for ether_rx_frame: builds frames with a computed FCS,
// drives them over GMII and checks the forwarded byte stream and verdicts.
module tb_ether_rx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        phy_rx_dv = 1'b0;
  logic        phy_rx_er = 1'b0;
  logic [7:0]  phy_rx_data = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof, out_eof, out_ok, out_err;
  logic [15:0] stat_good, stat_bad;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t6 = -1;
  int viol = 0;
  int exp_good = 0;
  int exp_bad = 0;

  logic [7:0] frm [0:2047];
  int         frm_len = 0;

  logic [7:0] cap_data [$];
  logic [3:0] cap_flag [$];
  int         cap_cyc  [$];

  ether_rx_frame dut (
    .phy_rx_clk (clk),
    .rst        (rst),
    .phy_rx_dv  (phy_rx_dv),
    .phy_rx_er  (phy_rx_er),
    .phy_rx_data(phy_rx_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_ok     (out_ok),
    .out_err    (out_err),
    .stat_good  (stat_good),
    .stat_bad   (stat_bad)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture output stream and flag-protocol violations away from the active edge.
  always @(negedge clk) begin
    if (out_valid) begin
      cap_data.push_back(out_data);
      cap_flag.push_back({out_sof, out_eof, out_ok, out_err});
      cap_cyc.push_back(cyc);
    end else if (out_sof | out_eof | out_ok | out_err) begin
      viol++;
    end
    if (out_eof && (out_ok == out_err)) viol++;
    if (!out_eof && (out_ok | out_err)) viol++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic clear_cap();
    cap_data.delete();
    cap_flag.delete();
    cap_cyc.delete();
  endtask

  task automatic build(input int n_pay, input logic [7:0] seed, input logic [7:0] fcs_xor);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_pay; i++) begin
      frm[i] = 8'(i) + seed;
      c = crc_upd(c, frm[i]);
    end
    c = ~c;
    frm[n_pay]     = c[7:0];
    frm[n_pay + 1] = c[15:8];
    frm[n_pay + 2] = c[23:16];
    frm[n_pay + 3] = c[31:24] ^ fcs_xor;
    frm_len = n_pay + 4;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk);
    #1;
    phy_rx_dv   = dv;
    phy_rx_er   = er;
    phy_rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input int er_idx, input logic er_pre, input int gap);
    for (int i = 0; i < 7; i++) drive(1'b1, er_pre, 8'h55);
    drive(1'b1, er_pre, 8'hD5);
    for (int k = 0; k < frm_len; k++) begin
      drive(1'b1, (k == er_idx), frm[k]);
      if (k == 5) t6 = cyc + 1;
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic analyze(input logic [7:0] seed, output int n, output int bad_data,
                         output int sofs, output int eofs, output logic sof_first,
                         output logic eof_last, output logic ok_last, output logic err_last);
    n = cap_data.size();
    bad_data = 0; sofs = 0; eofs = 0;
    sof_first = 1'b0; eof_last = 1'b0; ok_last = 1'b0; err_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (cap_data[i] !== 8'(8'(i) + seed)) bad_data++;
      if (cap_flag[i][3]) sofs++;
      if (cap_flag[i][2]) eofs++;
    end
    if (n > 0) begin
      sof_first = cap_flag[0][3];
      eof_last  = cap_flag[n-1][2];
      ok_last   = cap_flag[n-1][1];
      err_last  = cap_flag[n-1][0];
    end
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if ({out_valid, out_data, out_sof, out_eof, out_ok, out_err} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {out_valid, out_data, out_sof, out_eof, out_ok, out_err});
    end
    checks++;
    if (stat_good !== 16'h0 || stat_bad !== 16'h0) begin
      errors++;
      $display("FAIL reset_stats: got good=%0d bad=%0d want 0/0", stat_good, stat_bad);
    end
    #3 rst = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    int n, bd, sc, ec; logic s0, e1, o1, r1;
    clear_cap();
    build(60, 8'h00, 8'h00);
    send(-1, 1'b0, 1);
    idle(4);
    exp_good++;
    analyze(8'h00, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 60) begin errors++; $display("FAIL good_len: got %0d want 60", n); end
    checks++;
    if (bd !== 0) begin errors++; $display("FAIL good_data: got %0d bad bytes want 0", bd); end
    checks++;
    if (sc !== 1 || s0 !== 1'b1) begin errors++; $display("FAIL good_sof: got count=%0d first=%b want 1/1", sc, s0); end
    checks++;
    if (ec !== 1 || e1 !== 1'b1) begin errors++; $display("FAIL good_eof: got count=%0d last=%b want 1/1", ec, e1); end
    checks++;
    if (o1 !== 1'b1 || r1 !== 1'b0) begin errors++; $display("FAIL good_verdict: got ok=%b err=%b want 1/0", o1, r1); end
    checks++;
    if (n == 0 || cap_cyc[0] !== t6) begin
      errors++;
      $display("FAIL good_latency: got cycle %0d want %0d", (n == 0) ? -1 : cap_cyc[0], t6);
    end
  endtask

  task automatic test_bad_fcs();
    int n, bd, sc, ec; logic s0, e1, o1, r1;
    clear_cap();
    build(60, 8'h00, 8'h01);
    send(-1, 1'b0, 1);
    idle(4);
    exp_bad++;
    analyze(8'h00, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 60 || bd !== 0) begin errors++; $display("FAIL fcs_data: got len=%0d bad=%0d want 60/0", n, bd); end
    checks++;
    if (e1 !== 1'b1 || o1 !== 1'b0 || r1 !== 1'b1) begin
      errors++; $display("FAIL fcs_verdict: got eof=%b ok=%b err=%b want 1/0/1", e1, o1, r1);
    end
  endtask

  task automatic test_runt();
    int n, bd, sc, ec; logic s0, e1, o1, r1;
    clear_cap();
    build(36, 8'h40, 8'h00);
    send(-1, 1'b0, 1);
    idle(4);
    exp_bad++;
    analyze(8'h40, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 36 || bd !== 0) begin errors++; $display("FAIL runt_data: got len=%0d bad=%0d want 36/0", n, bd); end
    checks++;
    if (e1 !== 1'b1 || o1 !== 1'b0 || r1 !== 1'b1) begin
      errors++; $display("FAIL runt_verdict: got eof=%b ok=%b err=%b want 1/0/1", e1, o1, r1);
    end
  endtask

  task automatic test_rx_er();
    int n, bd, sc, ec; logic s0, e1, o1, r1;
    clear_cap();
    build(60, 8'h80, 8'h00);
    send(10, 1'b0, 1);
    idle(4);
    exp_bad++;
    analyze(8'h80, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 60 || bd !== 0) begin errors++; $display("FAIL rxer_data: got len=%0d bad=%0d want 60/0", n, bd); end
    checks++;
    if (e1 !== 1'b1 || o1 !== 1'b0 || r1 !== 1'b1) begin
      errors++; $display("FAIL rxer_verdict: got eof=%b ok=%b err=%b want 1/0/1", e1, o1, r1);
    end
  endtask

  task automatic test_preamble();
    int n, bd, sc, ec; logic s0, e1, o1, r1;
    // phy_rx_er during preamble/SFD must not taint the frame.
    clear_cap();
    build(60, 8'h20, 8'h00);
    send(-1, 1'b1, 1);
    idle(4);
    exp_good++;
    analyze(8'h20, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 60 || bd !== 0 || o1 !== 1'b1 || r1 !== 1'b0) begin
      errors++; $display("FAIL pre_er_ignored: got len=%0d bad=%0d ok=%b err=%b want 60/0/1/0", n, bd, o1, r1);
    end
    // A corrupt preamble byte drops the whole burst.
    clear_cap();
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h12);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int k = 0; k < frm_len; k++) drive(1'b1, 1'b0, frm[k]);
    idle(4);
    checks++;
    if (cap_data.size() !== 0) begin errors++; $display("FAIL pre_bad_drop: got %0d bytes want 0", cap_data.size()); end
  endtask

  task automatic test_tiny();
    int n, bd, sc, ec; logic s0, e1, o1, r1;
    // Three bytes after SFD: nothing emitted at all.
    clear_cap();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    drive(1'b1, 1'b0, 8'hA1);
    drive(1'b1, 1'b0, 8'hA2);
    drive(1'b1, 1'b0, 8'hA3);
    idle(4);
    exp_bad++;
    checks++;
    if (cap_data.size() !== 0) begin errors++; $display("FAIL tiny3_silent: got %0d bytes want 0", cap_data.size()); end
    // Five bytes after SFD: one byte with sof, eof and err together.
    clear_cap();
    build(1, 8'h77, 8'h00);
    send(-1, 1'b0, 1);
    idle(4);
    exp_bad++;
    analyze(8'h77, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 1 || bd !== 0 || s0 !== 1'b1 || e1 !== 1'b1 || o1 !== 1'b0 || r1 !== 1'b1) begin
      errors++;
      $display("FAIL tiny5_single: got len=%0d bad=%0d sof=%b eof=%b ok=%b err=%b want 1/0/1/1/0/1", n, bd, s0, e1, o1, r1);
    end
  endtask

  task automatic test_max_len();
    int n, bd, sc, ec; logic s0, e1, o1, r1;
    clear_cap();
    build(1514, 8'h33, 8'h00);
    send(-1, 1'b0, 1);
    idle(4);
    exp_good++;
    analyze(8'h33, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 1514 || bd !== 0 || o1 !== 1'b1 || r1 !== 1'b0) begin
      errors++; $display("FAIL max_ok: got len=%0d bad=%0d ok=%b err=%b want 1514/0/1/0", n, bd, o1, r1);
    end
    clear_cap();
    build(1515, 8'h44, 8'h00);
    send(-1, 1'b0, 1);
    idle(4);
    exp_bad++;
    analyze(8'h44, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 1515 || bd !== 0 || e1 !== 1'b1 || o1 !== 1'b0 || r1 !== 1'b1) begin
      errors++; $display("FAIL oversize_err: got len=%0d bad=%0d eof=%b ok=%b err=%b want 1515/0/1/0/1", n, bd, e1, o1, r1);
    end
  endtask

  task automatic test_stats();
    logic [15:0] wg, wb;
`ifdef ETHER_RX_FRAME_STATS_EN
    wg = 16'(exp_good);
    wb = 16'(exp_bad);
`else
    wg = 16'h0;
    wb = 16'h0;
`endif
    checks++;
    if (stat_good !== wg || stat_bad !== wb) begin
      errors++; $display("FAIL stats_tally: got good=%0d bad=%0d want %0d/%0d", stat_good, stat_bad, wg, wb);
    end
  endtask

  task automatic test_mid_reset();
    int n, bd, sc, ec; logic s0, e1, o1, r1;
    clear_cap();
    build(60, 8'h10, 8'h00);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, frm[k]);
    #3;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got valid=%b want 1", out_valid); end
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_sof, out_eof, out_ok, out_err} !== 13'h0 || stat_good !== 16'h0 || stat_bad !== 16'h0) begin
      errors++;
      $display("FAIL midrst_clear: got out=%h good=%0d bad=%0d want 0", {out_valid, out_data, out_sof, out_eof, out_ok, out_err}, stat_good, stat_bad);
    end
    exp_good = 0;
    exp_bad = 0;
    clear_cap();
    for (int k = 20; k < frm_len; k++) begin
      drive(1'b1, 1'b0, frm[k]);
      if (k == 21) #2 rst = 1'b1;
    end
    idle(4);
    checks++;
    if (cap_data.size() !== 0) begin errors++; $display("FAIL midrst_discard: got %0d bytes want 0", cap_data.size()); end
    clear_cap();
    build(60, 8'h30, 8'h00);
    send(-1, 1'b0, 1);
    idle(4);
    exp_good++;
    analyze(8'h30, n, bd, sc, ec, s0, e1, o1, r1);
    checks++;
    if (n !== 60 || bd !== 0 || o1 !== 1'b1 || r1 !== 1'b0) begin
      errors++; $display("FAIL midrst_next: got len=%0d bad=%0d ok=%b err=%b want 60/0/1/0", n, bd, o1, r1);
    end
  endtask

  task automatic test_back_to_back();
    int n, bd, eofs, oks;
    logic [15:0] wg;
    #2 rst = 1'b0;
    #7 rst = 1'b1;
    exp_good = 0;
    exp_bad = 0;
    idle(2);
    clear_cap();
    build(60, 8'h05, 8'h00);
    send(-1, 1'b0, 1);
    build(60, 8'h60, 8'h00);
    send(-1, 1'b0, 1);
    idle(4);
    exp_good += 2;
    n = cap_data.size();
    bd = 0; eofs = 0; oks = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 60 && cap_data[i] !== 8'(8'(i) + 8'h05)) bd++;
      if (i >= 60 && cap_data[i] !== 8'(8'(i - 60) + 8'h60)) bd++;
      if (cap_flag[i][2]) eofs++;
      if (cap_flag[i][2] && cap_flag[i][1]) oks++;
    end
    checks++;
    if (n !== 120 || bd !== 0) begin errors++; $display("FAIL b2b_data: got len=%0d bad=%0d want 120/0", n, bd); end
    checks++;
    if (eofs !== 2 || oks !== 2 || (n == 120 && (cap_flag[59][2] !== 1'b1 || cap_flag[60][3] !== 1'b1))) begin
      errors++; $display("FAIL b2b_eof: got eofs=%0d oks=%0d want 2/2 at bytes 59 and 119", eofs, oks);
    end
`ifdef ETHER_RX_FRAME_STATS_EN
    wg = 16'd2;
`else
    wg = 16'd0;
`endif
    checks++;
    if (stat_good !== wg || stat_bad !== 16'd0) begin
      errors++; $display("FAIL b2b_stats: got good=%0d bad=%0d want %0d/0", stat_good, stat_bad, wg);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL flag_protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_runt();
    test_rx_er();
    test_preamble();
    test_tiny();
    test_max_len();
    test_stats();
    test_mid_reset();
    test_stats();
    test_back_to_back();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
